sim_run_ctrl: RTL and testbench



---
 rtl/sim_run_ctrl_pkg.sv | 19 +
 rtl/sim_run_ctrl_hang_detect.sv | 42 ++++
 rtl/sim_run_ctrl.sv | 133 +++++++++++++
 tb/tb_sim_run_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/sim_run_ctrl_pkg.sv
// Shared types for the simulation run controller: FSM states and the
// terminate status codes reported in the status word.
package sim_run_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RESET = 2'd1,
      RUN   = 2'd2,
      DONE  = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      ST_PASS    = 2'd0,
      ST_FAIL    = 2'd1,
      ST_HANG    = 2'd2,
      ST_TIMEOUT = 2'd3
   } status_e;

endpackage

// File: rtl/sim_run_ctrl_hang_detect.sv
// PC hang detector: flags the HANG_CYCLES-th consecutive RUN sample whose pc
// equals the previous sample. The first enabled sample never counts as equal.
module hang_detect #(
   parameter int ADDR_W      = 32,
   parameter int HANG_CYCLES = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr_i,
   input  logic              en_i,
   input  logic [ADDR_W-1:0] pc_i,
   output logic              hit_o
);

   localparam int HC_W = $clog2(HANG_CYCLES);
   localparam logic [HC_W-1:0] HC_LOAD = HC_W'(HANG_CYCLES - 1);

   logic [ADDR_W-1:0] pc_q;
   logic              valid_q;
   logic [HC_W-1:0]   cnt_q;
   logic              same;

   assign same  = valid_q && (pc_i == pc_q);
   assign hit_o = en_i && same && (cnt_q == '0);

   // Down-counter reloads on every pc change; terminal count 0 is the hang.
   always_ff @(posedge clk) begin
      if (rst || clr_i) begin
         pc_q    <= '0;
         valid_q <= 1'b0;
         cnt_q   <= HC_LOAD;
      end else if (en_i) begin
         pc_q    <= pc_i;
         valid_q <= 1'b1;
         if (!same)
            cnt_q <= HC_LOAD;
         else if (cnt_q != '0)
            cnt_q <= cnt_q - 1'b1;
      end
   end

endmodule

// File: rtl/sim_run_ctrl.sv
// Run controller beside the core: sequences core reset, counts run cycles
// and latches a pass/fail/hang/timeout status word.
//
//   state | meaning
//   IDLE  | after rst, core held in reset, waiting for start
//   RESET | core held in reset for RESET_CYCLES cycles, results cleared
//   RUN   | core released, cycles counted, terminate events watched
//   DONE  | core held in reset, results frozen until start or rst
module sim_run_ctrl
   import sim_run_pkg::*;
#(
   parameter int                ADDR_W       = 32,
   parameter int                DATA_W       = 32,
   parameter int                RESET_CYCLES = 3,
   parameter int                MAX_CYCLES   = 1000,
   parameter int                HANG_CYCLES  = 16,
   parameter int                CNT_W        = 32,
   parameter logic [ADDR_W-1:0] TOHOST_ADDR  = 32'h0000_0100
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] pc,
   input  logic              mem_we,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   output logic              core_rst_n,
   output logic              running,
   output logic              done,
   output logic              pass,
   output logic [1:0]        status,
   output logic [DATA_W-2:0] fail_code,
   output logic [CNT_W-1:0]  cycle_count
);

   localparam int RC_W = $clog2(RESET_CYCLES + 1);

   state_e            state_q, state_d;
   logic [RC_W-1:0]   rcnt_q;
   logic [CNT_W-1:0]  cycle_q;
   logic              pass_q;
   status_e           status_q;
   logic [DATA_W-2:0] fc_q;
   logic              crn_q;

   logic in_run, enter_reset, hang_hit, ev_tohost, ev_timeout, term;

   assign in_run      = (state_q == RUN);
   assign enter_reset = start && ((state_q == IDLE) || (state_q == DONE));
   assign ev_tohost   = mem_we && (mem_addr == TOHOST_ADDR) && (mem_wdata != '0);
   // Widened compare so a narrow counter simply never reaches the budget.
   assign ev_timeout  = (64'(cycle_q) == 64'(MAX_CYCLES - 1));
   assign term        = ev_tohost || hang_hit || ev_timeout;

   hang_detect #(
      .ADDR_W      (ADDR_W),
      .HANG_CYCLES (HANG_CYCLES)
   ) u_hang (
      .clk   (clk),
      .rst   (rst),
      .clr_i (enter_reset),
      .en_i  (in_run),
      .pc_i  (pc),
      .hit_o (hang_hit)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:  if (start)          state_d = RESET;
         RESET: if (rcnt_q == '0)   state_d = RUN;
         RUN:   if (term)           state_d = DONE;
         DONE:  if (start)          state_d = RESET;
         default:                   state_d = IDLE;
      endcase
   end

   always_comb begin
      running = in_run;
      done    = (state_q == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rcnt_q   <= '0;
         cycle_q  <= '0;
         pass_q   <= 1'b0;
         status_q <= ST_PASS;
         fc_q     <= '0;
         crn_q    <= 1'b0;
      end else begin
         crn_q <= (state_d == RUN);
         if (enter_reset) begin
            rcnt_q   <= RC_W'(RESET_CYCLES - 1);
            cycle_q  <= '0;
            pass_q   <= 1'b0;
            status_q <= ST_PASS;
            fc_q     <= '0;
         end else if ((state_q == RESET) && (rcnt_q != '0)) begin
            rcnt_q <= rcnt_q - 1'b1;
         end
         if (in_run) begin
            if (cycle_q != '1)
               cycle_q <= cycle_q + 1'b1;
            if (ev_tohost) begin
               if (mem_wdata == DATA_W'(1)) begin
                  pass_q   <= 1'b1;
                  status_q <= ST_PASS;
               end else begin
                  status_q <= ST_FAIL;
                  fc_q     <= mem_wdata[DATA_W-1:1];
               end
            end else if (hang_hit) begin
               status_q <= ST_HANG;
            end else if (ev_timeout) begin
               status_q <= ST_TIMEOUT;
            end
         end
      end
   end

   assign core_rst_n  = crn_q;
   assign pass        = pass_q;
   assign status      = status_q;
   assign fail_code   = fc_q;
   assign cycle_count = cycle_q;

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Directed bench for sim_run_ctrl: a vector table for reset/start/pass,
// then hand sequences for fail, hang, timeout, saturation and abort.
module tb_sim_run_ctrl;

   logic        clk = 1'b0;
   logic        rst, start, mem_we;
   logic [31:0] pc, mem_addr, mem_wdata;

   logic        core_rst_n, running, done, pass;
   logic [1:0]  status;
   logic [30:0] fail_code;
   logic [31:0] cycle_count;

   logic        s_core_rst_n, s_running, s_done, s_pass;
   logic [1:0]  s_status;
   logic [30:0] s_fail_code;
   logic [3:0]  s_cycle_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sim_run_ctrl #(.MAX_CYCLES(20)) dut (
      .clk(clk), .rst(rst), .start(start), .pc(pc), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .core_rst_n(core_rst_n),
      .running(running), .done(done), .pass(pass), .status(status),
      .fail_code(fail_code), .cycle_count(cycle_count)
   );

   sim_run_ctrl #(.CNT_W(4), .MAX_CYCLES(100), .HANG_CYCLES(64)) dut_s (
      .clk(clk), .rst(rst), .start(start), .pc(pc), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .core_rst_n(s_core_rst_n),
      .running(s_running), .done(s_done), .pass(s_pass), .status(s_status),
      .fail_code(s_fail_code), .cycle_count(s_cycle_count)
   );

   typedef struct {
      logic        rst, start;
      logic [31:0] pc;
      logic        we;
      logic [31:0] addr, wdata;
      logic        e_crn, e_run, e_done, e_pass;
      logic [1:0]  e_st;
      logic [30:0] e_fc;
      logic [31:0] e_cnt;
   } vec_t;

   vec_t tbl[16];

   function automatic vec_t mk(input logic r, input logic s, input logic [31:0] p,
                               input logic w, input logic [31:0] a, input logic [31:0] d,
                               input logic crn, input logic run, input logic dn,
                               input logic ps, input logic [1:0] st,
                               input logic [30:0] fc, input logic [31:0] cnt);
      vec_t v;
      v.rst = r; v.start = s; v.pc = p; v.we = w; v.addr = a; v.wdata = d;
      v.e_crn = crn; v.e_run = run; v.e_done = dn; v.e_pass = ps;
      v.e_st = st; v.e_fc = fc; v.e_cnt = cnt;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_bus(input logic [31:0] p);
      pc = p; mem_we = 1'b0; mem_addr = 32'h0; mem_wdata = 32'h0;
   endtask

   task automatic store(input logic [31:0] p, input logic [31:0] a, input logic [31:0] d);
      pc = p; mem_we = 1'b1; mem_addr = a; mem_wdata = d;
   endtask

   task automatic do_reset();
      rst = 1'b1; start = 1'b0; idle_bus(32'h0);
      tick(); tick();
      rst = 1'b0;
   endtask

   // Start pulse then the three RESET cycles; leaves the DUT in RUN.
   task automatic start_run(input string nm);
      start = 1'b1; idle_bus(32'h0);
      tick();
      start = 1'b0;
      chk({nm, "_cleared_done"}, done, 0);
      chk({nm, "_cleared_cnt"}, cycle_count, 0);
      chk({nm, "_cleared_pass"}, pass, 0);
      tick(); tick(); tick();
      chk({nm, "_in_run"}, running, 1);
   endtask

   initial begin
      int n;
      rst = 1'b1; start = 1'b0; idle_bus(32'h0);

      tbl[0]  = mk(1,0,32'h0,  0,32'h0,  0, 0,0,0,0,0,0,0);
      tbl[1]  = mk(1,0,32'h0,  0,32'h0,  0, 0,0,0,0,0,0,0);
      tbl[2]  = mk(0,1,32'h0,  0,32'h0,  0, 0,0,0,0,0,0,0);
      tbl[3]  = mk(0,0,32'h0,  0,32'h0,  0, 0,0,0,0,0,0,0);
      tbl[4]  = mk(0,0,32'h0,  0,32'h0,  0, 0,0,0,0,0,0,0);
      tbl[5]  = mk(0,0,32'h0,  0,32'h0,  0, 1,1,0,0,0,0,0);
      tbl[6]  = mk(0,0,32'h204,0,32'h0,  0, 1,1,0,0,0,0,1);
      tbl[7]  = mk(0,0,32'h208,0,32'h0,  0, 1,1,0,0,0,0,2);
      tbl[8]  = mk(0,0,32'h20c,0,32'h0,  0, 1,1,0,0,0,0,3);
      tbl[9]  = mk(0,1,32'h210,0,32'h0,  0, 1,1,0,0,0,0,4);
      tbl[10] = mk(0,0,32'h214,1,32'h100,0, 1,1,0,0,0,0,5);
      tbl[11] = mk(0,0,32'h218,1,32'h104,1, 1,1,0,0,0,0,6);
      tbl[12] = mk(0,0,32'h21c,0,32'h0,  0, 1,1,0,0,0,0,7);
      tbl[13] = mk(0,0,32'h220,0,32'h0,  0, 1,1,0,0,0,0,8);
      tbl[14] = mk(0,0,32'h224,0,32'h0,  0, 1,1,0,0,0,0,9);
      tbl[15] = mk(0,0,32'h228,1,32'h100,1, 0,0,1,1,0,0,10);

      for (int i = 0; i < 16; i++) begin
         rst = tbl[i].rst; start = tbl[i].start; pc = tbl[i].pc;
         mem_we = tbl[i].we; mem_addr = tbl[i].addr; mem_wdata = tbl[i].wdata;
         tick();
         chk($sformatf("v%0d_core_rst_n", i), core_rst_n, tbl[i].e_crn);
         chk($sformatf("v%0d_running", i), running, tbl[i].e_run);
         chk($sformatf("v%0d_done", i), done, tbl[i].e_done);
         chk($sformatf("v%0d_pass", i), pass, tbl[i].e_pass);
         chk($sformatf("v%0d_status", i), status, tbl[i].e_st);
         chk($sformatf("v%0d_fail_code", i), fail_code, tbl[i].e_fc);
         chk($sformatf("v%0d_cycle_count", i), cycle_count, tbl[i].e_cnt);
      end
      start = 1'b0; idle_bus(32'h0);

      // Fail store of 7 at run cycle 3, then results must hold in DONE.
      start_run("fail");
      idle_bus(32'h300); tick();
      idle_bus(32'h304); tick();
      store(32'h308, 32'h100, 32'd7); tick();
      chk("fail_done", done, 1);
      chk("fail_status", status, 1);
      chk("fail_code", fail_code, 3);
      chk("fail_pass", pass, 0);
      chk("fail_cnt", cycle_count, 3);
      store(32'h30c, 32'h100, 32'd1); tick();
      chk("fail_hold_status", status, 1);
      chk("fail_hold_done", done, 1);

      // pc stuck at 0x40 from the first run cycle: 16 equal samples follow.
      start_run("hang");
      idle_bus(32'h40);
      n = 0;
      while (n < 40 && !done) begin
         tick();
         n++;
      end
      chk("hang_done", done, 1);
      chk("hang_status", status, 2);
      chk("hang_cycles", n, 17);
      chk("hang_cnt", cycle_count, 17);

      // Timeout with pc always changing; narrow instance saturates.
      do_reset();
      start_run("timeout");
      for (int k = 1; k <= 20; k++) begin
         idle_bus(32'h1000 + 32'(k) * 4);
         tick();
         if (k == 19) chk("timeout_not_early", done, 0);
      end
      chk("timeout_done", done, 1);
      chk("timeout_status", status, 3);
      chk("timeout_cnt", cycle_count, 20);
      chk("timeout_pass", pass, 0);
      for (int k = 21; k <= 30; k++) begin
         idle_bus(32'h1000 + 32'(k) * 4);
         tick();
      end
      chk("sat_cnt", s_cycle_count, 15);
      chk("sat_running", s_running, 1);

      // Tohost pass on the same cycle as the timeout: pass wins.
      start_run("coinc");
      for (int k = 1; k <= 19; k++) begin
         idle_bus(32'h2000 + 32'(k) * 4);
         tick();
      end
      store(32'h2100, 32'h100, 32'd1); tick();
      chk("coinc_done", done, 1);
      chk("coinc_status", status, 0);
      chk("coinc_pass", pass, 1);
      chk("coinc_cnt", cycle_count, 20);

      // rst at run cycle 5 aborts straight to IDLE.
      start_run("abort");
      for (int k = 1; k <= 4; k++) begin
         idle_bus(32'h3000 + 32'(k) * 4);
         tick();
      end
      rst = 1'b1; idle_bus(32'h3100); tick();
      chk("abort_crn", core_rst_n, 0);
      chk("abort_running", running, 0);
      chk("abort_done", done, 0);
      chk("abort_pass", pass, 0);
      chk("abort_status", status, 0);
      chk("abort_cnt", cycle_count, 0);
      rst = 1'b0; tick();
      chk("abort_stays_idle", running, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
